ret_reg_logger: RTL and testbench

RET_REG_LOGGER -- requirements
Module: ret_reg_logger

---
 rtl/kgp_pkg.sv | 9 +
 rtl/ret_fifo.sv | 76 +++++++
 rtl/ret_reg_logger.sv | 92 +++++++++
 tb/tb_ret_reg_logger.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// Shared defaults for the return-register logger: data width, FIFO depth
// and the pointer width derived from that depth.
package kgp_pkg;

  localparam int unsigned RET_WIDTH = 32;
  localparam int unsigned RET_DEPTH = 8;
  localparam int unsigned RET_PTR_W = $clog2(RET_DEPTH);

endpackage

// File: rtl/ret_fifo.sv
// Synchronous FIFO that holds captured return values. The head entry comes
// straight from storage, and a push into a full FIFO is accepted only when a pop happens in the same cycle.
module ret_fifo
  import kgp_pkg::*;
#(
  parameter int WIDTH = RET_WIDTH,
  parameter int DEPTH = RET_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop on an empty FIFO is ignored; a full FIFO only accepts a push that
  // replaces the entry leaving in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ret_reg_logger.sv
// Logs every change of the processor return register while the core runs,
// queuing values for a ready/valid consumer and counting changes dropped on a full FIFO.
module ret_reg_logger
  import kgp_pkg::*;
#(
  parameter int WIDTH = RET_WIDTH,
  parameter int DEPTH = RET_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ret_val,
  input  logic             core_run,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow,
  output logic [7:0]       drop_cnt,
  output logic [PTR_W:0]   level
);

  logic [WIDTH-1:0] last_val_q, last_val_d;
  logic             armed_q, armed_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             change;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign change    = core_run && (!armed_q || (ret_val != last_val_q));
  assign pop       = out_valid && out_ready;
  assign drop      = change && fifo_full && !pop;
  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // last_val follows every change event, even a dropped one, so a repeated
  // value is not re-offered once space frees up.
  always_comb begin
    last_val_d = last_val_q;
    armed_d    = armed_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (change) begin
      last_val_d = ret_val;
      armed_d    = 1'b1;
    end
    if (!core_run) begin
      armed_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc8(drop_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_val_q <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      last_val_q <= last_val_d;
      armed_q    <= armed_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ret_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (change),
    .pop  (pop),
    .din  (ret_val),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(level),
    .dout (out_data)
  );

endmodule

// File: tb/tb_ret_reg_logger.sv
// Bench for ret_reg_logger: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the capture rules.
module tb_ret_reg_logger;

  localparam int W = 32;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  ret_val;
  logic          core_run;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic [3:0]    level;

  int n_chk = 0;
  int n_bad = 0;

  logic [W-1:0] q[$];
  logic         m_armed;
  logic [W-1:0] m_last;
  logic         m_ovf;
  int           m_drop;

  always #5 clk = ~clk;

  ret_reg_logger #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .ret_val  (ret_val),
    .core_run (core_run),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .level    (level)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_armed = 1'b0;
    m_last  = '0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, out_valid, (q.size() != 0));
    chk({tag, ".level"}, level, q.size());
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".drop"}, drop_cnt, m_drop);
    if (q.size() != 0) chk({tag, ".data"}, out_data, q[0]);
  endtask

  // One clock cycle: drive at the falling edge, apply the rules to the
  // model, then compare just after the rising edge.
  task automatic step(input logic run, input logic [W-1:0] val, input logic rdy, input string tag);
    logic ch, pp, was_full;
    @(negedge clk);
    core_run  = run;
    ret_val   = val;
    out_ready = rdy;
    ch       = run && (!m_armed || val != m_last);
    pp       = rdy && (q.size() != 0);
    was_full = (q.size() == D);
    if (pp) void'(q.pop_front());
    if (ch) begin
      if (!was_full || pp) q.push_back(val);
      else begin
        m_ovf  = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
      m_last  = val;
      m_armed = 1'b1;
    end
    if (!run) m_armed = 1'b0;
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, out_valid, 1'b0);
    chk({tag, ".rst_data"}, out_data, '0);
    chk({tag, ".rst_level"}, level, '0);
    chk({tag, ".rst_ovf"}, overflow, 1'b0);
    chk({tag, ".rst_drop"}, drop_cnt, '0);
    model_clear();
    core_run  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    core_run  = 1'b0;
    ret_val   = '0;
    out_ready = 1'b0;
    model_clear();
    #2;
    chk("init_valid", out_valid, 1'b0);
    chk("init_data", out_data, '0);
    chk("init_level", level, '0);
    chk("init_ovf", overflow, 1'b0);
    chk("init_drop", drop_cnt, '0);
    @(negedge clk);
    rst = 1'b1;

    // No capture while the core is stopped, even right after release.
    step(1'b0, 32'd9, 1'b1, "idle");

    // Basic capture 0 -> 5 -> 5 -> -3 with a ready consumer.
    step(1'b1, 32'd0, 1'b1, "cap0");
    step(1'b1, 32'd5, 1'b1, "cap5");
    step(1'b1, 32'd5, 1'b1, "cap5b");
    step(1'b1, 32'hFFFF_FFFD, 1'b1, "capm3");
    step(1'b1, 32'hFFFF_FFFD, 1'b1, "capm3b");
    step(1'b1, 32'hFFFF_FFFD, 1'b1, "capm3c");

    // Overflow: ten distinct values into an eight-entry FIFO.
    do_reset("ovf");
    for (int i = 0; i < 10; i++) step(1'b1, 32'd100 + i, 1'b0, "ovf_fill");
    chk("ovf_level8", level, 8);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_drop2", drop_cnt, 2);
    for (int i = 0; i < 8; i++) step(1'b1, 32'd109, 1'b1, "ovf_drain");
    chk("ovf_empty", level, 0);

    // Push and pop together on a full FIFO.
    do_reset("pp");
    for (int i = 0; i < 8; i++) step(1'b1, 32'd200 + i, 1'b0, "pp_fill");
    step(1'b1, 32'd300, 1'b1, "pp_both");
    chk("pp_level8", level, 8);
    chk("pp_nodrop", drop_cnt, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'd300, 1'b1, "pp_drain");

    // Re-arm: a constant 7 is captured again after core_run drops.
    do_reset("rearm");
    step(1'b1, 32'd7, 1'b0, "rearm_a");
    step(1'b0, 32'd7, 1'b0, "rearm_b");
    step(1'b1, 32'd7, 1'b0, "rearm_c");
    chk("rearm_level2", level, 2);
    step(1'b0, 32'd7, 1'b1, "rearm_d0");
    step(1'b0, 32'd7, 1'b1, "rearm_d1");

    // Reset mid-operation with four entries queued.
    do_reset("mid");
    for (int i = 0; i < 4; i++) step(1'b1, 32'd50 + i, 1'b0, "mid_fill");
    chk("mid_level4", level, 4);
    do_reset("mid");
    step(1'b1, 32'd50, 1'b1, "mid_after");

    // Saturation of the drop counter.
    do_reset("sat");
    for (int i = 0; i < 308; i++) step(1'b1, 32'd1000 + i, 1'b0, "sat");
    chk("sat_drop255", drop_cnt, 255);
    chk("sat_ovf", overflow, 1'b1);

    // Random traffic over a small value set so repeats are frequent.
    do_reset("rnd");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset("rnd");
      step(($urandom_range(0, 7) != 0), W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
